// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the loadable instruction memory.
//   imem_state_e  : load/fetch controller states (EMPTY, LOAD, READY)
//   word_bytes_t  : four bytes read at PC..PC+3, element [0] is the byte at PC
//   NOP_INSTR     : instruction word returned for faulting or unloaded fetches
//   pack_word()   : orders the four fetched bytes into a 32-bit instruction
// -----------------------------------------------------------------------------
package imem_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } imem_state_e;

   typedef logic [3:0][7:0] word_bytes_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Big-endian puts the byte at PC in the top lane; little-endian in the bottom.
   function automatic logic [31:0] pack_word(input word_bytes_t bytes, input logic big_endian);
      if (big_endian) begin
         return {bytes[0], bytes[1], bytes[2], bytes[3]};
      end
      return {bytes[3], bytes[2], bytes[1], bytes[0]};
   endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// -----------------------------------------------------------------------------
// imem_byte_ram
// DEPTH_BYTES x 8 storage with one byte-wide write port and one registered
// 4-byte read port returning the bytes at raddr..raddr+3 (addresses wrap).
//   clk_i     : clock
//   we_i      : byte write enable
//   waddr_i   : byte write address
//   wdata_i   : byte write data
//   re_i      : read enable; rdata_o holds when low
//   raddr_i   : byte read address of the first byte
//   rdata_o   : registered read data, element [0] is the byte at raddr_i
// -----------------------------------------------------------------------------
module imem_byte_ram
   import imem_pkg::*;
#(
   parameter int DEPTH_BYTES = 256,
   parameter int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [7:0]           wdata_i,
   input  logic                 re_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output word_bytes_t          rdata_o
);

   logic [7:0]  mem_q [DEPTH_BYTES];
   word_bytes_t rdata_q;

   // NOTE: storage arrays get no reset; clearing them would need a reset port
   // per entry and a program image is always reloaded before use anyway.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         for (int i = 0; i < 4; i++) begin
            rdata_q[i] <= mem_q[raddr_i + ADDR_BITS'(i)];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
// Loadable instruction memory between the PC register and IF/ID. A byte-serial
// load port fills the memory from address 0; a stallable fetch port returns
// the 32-bit word at PC one cycle after acceptance, with alignment/range checks.
//   clk_i, reset_ni        : clock, asynchronous active-low reset
//   ld_start_i             : pulse, (re)starts a load at byte 0
//   ld_valid_i/ld_data_i   : load byte handshake and data
//   ld_last_i              : final byte of the image (qualified by ld_valid_i)
//   ld_ready_o             : controller is in LOAD
//   ld_err_o               : sticky overflow flag, cleared by ld_start_i
//   prog_len_o             : number of bytes loaded
//   fetch_req_i/fetch_pc_i : fetch request and byte address
//   stall_i                : hold fetch outputs, ignore the request
//   fetch_ready_o          : controller is in READY
//   fetch_valid_o/instr_o  : registered fetch result
//   fetch_fault_o          : registered misaligned/out-of-range flag
// -----------------------------------------------------------------------------
module imem_fetch_unit
   import imem_pkg::*;
#(
   parameter int DEPTH_BYTES = 256,
   parameter int ADDR_W      = 32,
   parameter bit BIG_ENDIAN  = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         ld_start_i,
   input  logic                         ld_valid_i,
   input  logic [7:0]                   ld_data_i,
   input  logic                         ld_last_i,
   output logic                         ld_ready_o,
   output logic                         ld_err_o,
   output logic [$clog2(DEPTH_BYTES):0] prog_len_o,
   input  logic                         fetch_req_i,
   input  logic [ADDR_W-1:0]            fetch_pc_i,
   input  logic                         stall_i,
   output logic                         fetch_ready_o,
   output logic                         fetch_valid_o,
   output logic [31:0]                  instr_o,
   output logic                         fetch_fault_o
);

   localparam int AW    = $clog2(DEPTH_BYTES);
   localparam int LEN_W = AW + 1;
   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH_BYTES);

   // ---------------------------------------------------------------- load FSM
   imem_state_e      state_q, state_d;
   logic             ld_ready_q, ld_ready_d;
   logic             fetch_ready_q, fetch_ready_d;
   logic             ld_err_q, ld_err_d;
   logic [LEN_W-1:0] prog_len_q, prog_len_d;   // doubles as the write pointer
   logic             mem_we;

   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      ld_err_d   = ld_err_q;
      prog_len_d = prog_len_q;
      mem_we     = 1'b0;
      if (ld_start_i) begin
         state_d    = ST_LOAD;
         ld_err_d   = 1'b0;
         prog_len_d = '0;
      end else if (state_q == ST_LOAD && ld_valid_i) begin
         if (prog_len_q == FULL_LEN) begin
            // Image larger than the memory: drop the byte and close the load.
            ld_err_d = 1'b1;
            state_d  = ST_READY;
         end else begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + LEN_W'(1);
            if (ld_last_i) begin
               state_d = ST_READY;
            end
         end
      end
      ld_ready_d    = (state_d == ST_LOAD);
      fetch_ready_d = (state_d == ST_READY);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q       <= ST_EMPTY;
         ld_ready_q    <= 1'b0;
         fetch_ready_q <= 1'b0;
         ld_err_q      <= 1'b0;
         prog_len_q    <= '0;
      end else begin
         state_q       <= state_d;
         ld_ready_q    <= ld_ready_d;
         fetch_ready_q <= fetch_ready_d;
         ld_err_q      <= ld_err_d;
         prog_len_q    <= prog_len_d;
      end
   end

   // ------------------------------------------------------------ fetch checks
   logic              fetch_accept;
   logic [ADDR_W:0]   pc_ext;
   logic              pc_fault;
   logic              pc_beyond;

   // ld_start_i wins over a simultaneous fetch.
   assign fetch_accept = fetch_req_i && fetch_ready_q && !stall_i && !ld_start_i;
   assign pc_ext       = {1'b0, fetch_pc_i};
   assign pc_fault     = (fetch_pc_i[1:0] != 2'b00) || (pc_ext >= (ADDR_W+1)'(DEPTH_BYTES));
   assign pc_beyond    = pc_ext >= (ADDR_W+1)'(prog_len_q);

   // ---------------------------------------------------------------- storage
   word_bytes_t rdata;

   imem_byte_ram #(
      .DEPTH_BYTES (DEPTH_BYTES),
      .ADDR_BITS   (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (prog_len_q[AW-1:0]),
      .wdata_i (ld_data_i),
      .re_i    (fetch_accept && !pc_fault && !pc_beyond),
      .raddr_i (fetch_pc_i[AW-1:0]),
      .rdata_o (rdata)
   );

   // ------------------------------------------------------- fetch output regs
   logic fetch_valid_q, fetch_valid_d;
   logic fetch_fault_q, fetch_fault_d;
   logic nop_q, nop_d;   // result is NOP rather than the RAM read word

   always_comb begin
      fetch_valid_d = fetch_valid_q;
      fetch_fault_d = fetch_fault_q;
      nop_d         = nop_q;
      if (fetch_accept) begin
         fetch_valid_d = 1'b1;
         fetch_fault_d = pc_fault;
         nop_d         = pc_fault || pc_beyond;
      end else if (!stall_i) begin
         // instr holds (nop_q and RAM data unchanged); only the flags drop.
         fetch_valid_d = 1'b0;
         fetch_fault_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         fetch_valid_q <= 1'b0;
         fetch_fault_q <= 1'b0;
         nop_q         <= 1'b1;
      end else begin
         fetch_valid_q <= fetch_valid_d;
         fetch_fault_q <= fetch_fault_d;
         nop_q         <= nop_d;
      end
   end

   // Both mux inputs are registers (nop_q and the RAM read register), so instr
   // changes only on a clock edge or reset, with no path from the inputs.
   assign instr_o       = nop_q ? NOP_INSTR : pack_word(rdata, BIG_ENDIAN);
   assign fetch_valid_o = fetch_valid_q;
   assign fetch_fault_o = fetch_fault_q;
   assign ld_ready_o    = ld_ready_q;
   assign fetch_ready_o = fetch_ready_q;
   assign ld_err_o      = ld_err_q;
   assign prog_len_o    = prog_len_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_unit
// Three instances: A (256 B, big-endian) and B (256 B, little-endian) share one
// stimulus; C (8 B, big-endian) has its own. Fetch expectations are queued by
// the stimulus and popped by per-instance monitors on each accepted request.
// -----------------------------------------------------------------------------
module tb_imem_fetch_unit;

   typedef struct {
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // shared stimulus for A and B
   logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic [7:0]  ld_data  = 8'h00;
   logic        fetch_req = 1'b0, stall = 1'b0;
   logic [31:0] fetch_pc  = 32'h0;

   // stimulus for C
   logic        c_ld_start = 1'b0, c_ld_valid = 1'b0, c_ld_last = 1'b0;
   logic [7:0]  c_ld_data  = 8'h00;
   logic        c_fetch_req = 1'b0, c_stall = 1'b0;
   logic [31:0] c_fetch_pc  = 32'h0;

   logic       a_ld_ready, a_ld_err, a_fetch_ready, a_fetch_valid, a_fault;
   logic [8:0] a_prog_len;
   logic [31:0] a_instr;
   logic       b_ld_ready, b_ld_err, b_fetch_ready, b_fetch_valid, b_fault;
   logic [8:0] b_prog_len;
   logic [31:0] b_instr;
   logic       c_ld_ready, c_ld_err, c_fetch_ready, c_fetch_valid, c_fault;
   logic [3:0] c_prog_len;
   logic [31:0] c_instr;

   imem_fetch_unit #(.DEPTH_BYTES(256), .ADDR_W(32), .BIG_ENDIAN(1'b1)) u_a (
      .clk_i(clk), .reset_ni(rst_n),
      .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
      .ld_ready_o(a_ld_ready), .ld_err_o(a_ld_err), .prog_len_o(a_prog_len),
      .fetch_req_i(fetch_req), .fetch_pc_i(fetch_pc), .stall_i(stall),
      .fetch_ready_o(a_fetch_ready), .fetch_valid_o(a_fetch_valid),
      .instr_o(a_instr), .fetch_fault_o(a_fault));

   imem_fetch_unit #(.DEPTH_BYTES(256), .ADDR_W(32), .BIG_ENDIAN(1'b0)) u_b (
      .clk_i(clk), .reset_ni(rst_n),
      .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
      .ld_ready_o(b_ld_ready), .ld_err_o(b_ld_err), .prog_len_o(b_prog_len),
      .fetch_req_i(fetch_req), .fetch_pc_i(fetch_pc), .stall_i(stall),
      .fetch_ready_o(b_fetch_ready), .fetch_valid_o(b_fetch_valid),
      .instr_o(b_instr), .fetch_fault_o(b_fault));

   imem_fetch_unit #(.DEPTH_BYTES(8), .ADDR_W(32), .BIG_ENDIAN(1'b1)) u_c (
      .clk_i(clk), .reset_ni(rst_n),
      .ld_start_i(c_ld_start), .ld_valid_i(c_ld_valid), .ld_data_i(c_ld_data), .ld_last_i(c_ld_last),
      .ld_ready_o(c_ld_ready), .ld_err_o(c_ld_err), .prog_len_o(c_prog_len),
      .fetch_req_i(c_fetch_req), .fetch_pc_i(c_fetch_pc), .stall_i(c_stall),
      .fetch_ready_o(c_fetch_ready), .fetch_valid_o(c_fetch_valid),
      .instr_o(c_instr), .fetch_fault_o(c_fault));

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t qa[$], qb[$], qc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitors
   logic acc_a = 1'b0, acc_b = 1'b0, acc_c = 1'b0;
   logic stl_ab = 1'b0, stl_c = 1'b0;

   always @(posedge clk) begin
      acc_a  <= fetch_req && a_fetch_ready && !stall && !ld_start;
      acc_b  <= fetch_req && b_fetch_ready && !stall && !ld_start;
      acc_c  <= c_fetch_req && c_fetch_ready && !c_stall && !c_ld_start;
      stl_ab <= stall;
      stl_c  <= c_stall;
   end

   always @(negedge clk) begin
      exp_t e;
      if (acc_a) begin
         if (qa.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL A response: got instr %h with no expectation queued", a_instr);
         end else begin
            e = qa.pop_front();
            check("A fetch_valid", 32'(a_fetch_valid), 32'd1);
            check("A instr", a_instr, e.instr);
            check("A fetch_fault", 32'(a_fault), 32'(e.fault));
         end
      end else if (!stl_ab) begin
         check("A idle fetch_valid", 32'(a_fetch_valid), 32'd0);
         check("A idle fetch_fault", 32'(a_fault), 32'd0);
      end
      if (acc_b) begin
         if (qb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL B response: got instr %h with no expectation queued", b_instr);
         end else begin
            e = qb.pop_front();
            check("B fetch_valid", 32'(b_fetch_valid), 32'd1);
            check("B instr", b_instr, e.instr);
            check("B fetch_fault", 32'(b_fault), 32'(e.fault));
         end
      end else if (!stl_ab) begin
         check("B idle fetch_valid", 32'(b_fetch_valid), 32'd0);
      end
      if (acc_c) begin
         if (qc.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL C response: got instr %h with no expectation queued", c_instr);
         end else begin
            e = qc.pop_front();
            check("C fetch_valid", 32'(c_fetch_valid), 32'd1);
            check("C instr", c_instr, e.instr);
            check("C fetch_fault", 32'(c_fault), 32'(e.fault));
         end
      end else if (!stl_c) begin
         check("C idle fetch_valid", 32'(c_fetch_valid), 32'd0);
      end
   end

   // ---------------------------------------------------------------- helpers
   logic [7:0] image [8] = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h8C, 8'h02, 8'h00, 8'h01};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ab(input int n, input logic mark_last);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = image[i];
         ld_last  = mark_last && (i == n - 1);
         step();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic fetch_ab(input logic [31:0] pc, input logic [31:0] ea,
                           input logic [31:0] eb, input logic fault);
      qa.push_back('{ea, fault});
      qb.push_back('{eb, fault});
      fetch_req = 1'b1;
      fetch_pc  = pc;
      step();
      fetch_req = 1'b0;
   endtask

   task automatic fetch_c(input logic [31:0] pc, input logic [31:0] e, input logic fault);
      qc.push_back('{e, fault});
      c_fetch_req = 1'b1;
      c_fetch_pc  = pc;
      step();
      c_fetch_req = 1'b0;
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, " ld_ready"},    32'(a_ld_ready),    32'd0);
      check({tag, " ld_err"},      32'(a_ld_err),      32'd0);
      check({tag, " prog_len"},    32'(a_prog_len),    32'd0);
      check({tag, " fetch_ready"}, 32'(a_fetch_ready), 32'd0);
      check({tag, " fetch_valid"}, 32'(a_fetch_valid), 32'd0);
      check({tag, " instr"},       a_instr,            32'h0);
      check({tag, " fetch_fault"}, 32'(a_fault),       32'd0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      #1 rst_n = 1'b0;
      #2;
      check_reset_a("reset A");
      check("reset C prog_len", 32'(c_prog_len), 32'd0);
      check("reset C fetch_ready", 32'(c_fetch_ready), 32'd0);
      step();
      step();
      rst_n = 1'b1;

      // load the 8-byte image into A and B
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      check("A ld_ready in LOAD", 32'(a_ld_ready), 32'd1);
      load_ab(8, 1'b1);
      check("A prog_len after load", 32'(a_prog_len), 32'd8);
      check("A fetch_ready after last", 32'(a_fetch_ready), 32'd1);
      check("A ld_ready after last", 32'(a_ld_ready), 32'd0);
      check("A ld_err after load", 32'(a_ld_err), 32'd0);
      check("B prog_len after load", 32'(b_prog_len), 32'd8);

      // normal, misaligned, beyond program, beyond memory
      fetch_ab(32'd0,   32'h8C01_0000, 32'h0000_018C, 1'b0);
      fetch_ab(32'd4,   32'h8C02_0001, 32'h0100_028C, 1'b0);
      fetch_ab(32'd2,   32'h0,         32'h0,         1'b1);
      fetch_ab(32'd12,  32'h0,         32'h0,         1'b0);
      fetch_ab(32'd256, 32'h0,         32'h0,         1'b1);

      // stall holds the PC 0 result while the PC moves
      fetch_ab(32'd0, 32'h8C01_0000, 32'h0000_018C, 1'b0);
      stall     = 1'b1;
      fetch_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fetch_pc = 32'(4 * (i + 1));
         step();
         check("A stall fetch_valid", 32'(a_fetch_valid), 32'd1);
         check("A stall instr", a_instr, 32'h8C01_0000);
         check("B stall instr", b_instr, 32'h0000_018C);
      end
      stall = 1'b0;
      fetch_ab(32'd4, 32'h8C02_0001, 32'h0100_028C, 1'b0);

      // ld_start beats a simultaneous fetch
      ld_start  = 1'b1;
      fetch_req = 1'b1;
      fetch_pc  = 32'd0;
      step();
      ld_start  = 1'b0;
      fetch_req = 1'b0;
      check("A fetch refused on ld_start", 32'(a_fetch_valid), 32'd0);
      check("A ld_ready after restart", 32'(a_ld_ready), 32'd1);
      check("A prog_len after restart", 32'(a_prog_len), 32'd0);

      // reset in the middle of a load
      load_ab(3, 1'b0);
      check("A prog_len mid-load", 32'(a_prog_len), 32'd3);
      rst_n = 1'b0;
      #2;
      check_reset_a("mid-load reset A");
      step();
      rst_n = 1'b1;
      fetch_req = 1'b1;
      fetch_pc  = 32'd0;
      step();
      fetch_req = 1'b0;
      check("A fetch before reload", 32'(a_fetch_valid), 32'd0);
      check("A instr before reload", a_instr, 32'h0);

      // clean reload
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      load_ab(8, 1'b1);
      check("A prog_len after reload", 32'(a_prog_len), 32'd8);
      fetch_ab(32'd4, 32'h8C02_0001, 32'h0100_028C, 1'b0);
      fetch_ab(32'd0, 32'h8C01_0000, 32'h0000_018C, 1'b0);

      // overflow on the 8-byte instance
      c_ld_start = 1'b1;
      step();
      c_ld_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         c_ld_valid = 1'b1;
         c_ld_data  = 8'h10 + 8'(i);
         c_ld_last  = (i == 8);
         step();
      end
      c_ld_valid = 1'b0;
      c_ld_last  = 1'b0;
      check("C ld_err on overflow", 32'(c_ld_err), 32'd1);
      check("C fetch_ready on overflow", 32'(c_fetch_ready), 32'd1);
      check("C ld_ready on overflow", 32'(c_ld_ready), 32'd0);
      check("C prog_len on overflow", 32'(c_prog_len), 32'd8);
      fetch_c(32'd0, 32'h1011_1213, 1'b0);
      fetch_c(32'd4, 32'h1415_1617, 1'b0);
      fetch_c(32'd8, 32'h0,         1'b1);
      c_ld_start = 1'b1;
      step();
      c_ld_start = 1'b0;
      check("C ld_err cleared by ld_start", 32'(c_ld_err), 32'd0);
      check("C prog_len cleared by ld_start", 32'(c_prog_len), 32'd0);
      check("C ld_ready after ld_start", 32'(c_ld_ready), 32'd1);

      step();
      step();
      check("A expectations drained", 32'(qa.size()), 32'd0);
      check("B expectations drained", 32'(qb.size()), 32'd0);
      check("C expectations drained", 32'(qc.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised, loadable instruction memory for the 5-stage MIPS pipeline, sitting between the PC register and the IF/ID pipeline register. It replaces the hard-wired reset-time program image with a byte-serial load port, so any program can be placed at run time. It also adds a registered, stallable fetch port with alignment and range checking. Instruction words are assembled from four bytes at PC..PC+3, with configurable byte order.

## Interface
- `DEPTH_BYTES`, default 256: memory size in bytes; must be a power of two and ≥ 4.
- `ADDR_W`, default 32: PC width; only the low log2(DEPTH_BYTES) bits index the memory.
- `BIG_ENDIAN`, default 1: 1 places the byte at PC in instr[31:24]; 0 places it in instr[7:0].
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `ld_start`, in, 1: one-cycle pulse that begins a program load at byte address 0.
- `ld_valid`, in, 1: a load byte is presented.
- `ld_data`, in, 8: the load byte.
- `ld_last`, in, 1: marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`, out, 1: high in LOAD state.
- `ld_err`, out, 1: sticky overflow flag, cleared by `ld_start` or reset.
- `prog_len`, out, log2(DEPTH_BYTES)+1: number of bytes loaded.
- `fetch_req`, in, 1: fetch request.
- `fetch_pc`, in, ADDR_W: byte address of the request.
- `stall`, in, 1: hold the fetch output; ignore the current request.
- `fetch_ready`, out, 1: high in READY state.
- `fetch_valid`, out, 1: registered; `instr` is valid.
- `instr`, out, 32: registered instruction word.
- `fetch_fault`, out, 1: registered; misaligned or out-of-range PC.

## Operation
- FSM states: EMPTY → LOAD → READY.
  - Reset enters EMPTY.
  - `ld_start` in any state enters LOAD, clears the write pointer, `prog_len` and `ld_err`.
  - In LOAD, `ld_last` accepted enters READY.
- Load:
  - Each cycle with `ld_valid && ld_ready`, `ld_data` is written to mem[ptr], then ptr and `prog_len` increment.
  - If a byte is accepted while ptr == DEPTH_BYTES, it is discarded, `ld_err` is set and the state moves to READY with `prog_len` = DEPTH_BYTES.
  - `ld_start` during LOAD restarts the load.
- Fetch acceptance: a request is accepted when `fetch_req && fetch_ready && !stall`.
- Fetch result, from an accepted request:
  - `fetch_pc[1:0] != 0` or `fetch_pc >= DEPTH_BYTES`: `fetch_fault`=1, `instr`=NOP (32'h0).
  - `fetch_pc >= prog_len`: no fault, `instr`=NOP.
  - Otherwise `instr` = the four bytes at PC..PC+3, ordered per `BIG_ENDIAN`.
- Non-accepted cycle: if `stall`=1, `fetch_valid`, `instr` and `fetch_fault` hold their values. If `stall`=0, `fetch_valid` and `fetch_fault` go to 0 and `instr` holds.
- Memory contents are not cleared by reset; reset only forces `prog_len`=0, so all fetches return NOP until a reload.

## Timing
- Reset values: state EMPTY, `ld_ready`=0, `ld_err`=0, `prog_len`=0, `fetch_ready`=0, `fetch_valid`=0, `instr`=0, `fetch_fault`=0.
- Fetch latency is 1 cycle: a request accepted at edge N drives `fetch_valid`/`instr` after edge N.
- Load throughput is 1 byte/cycle. `fetch_ready` rises the cycle after `ld_last` is accepted.
- Read/write same cycle is impossible by construction: fetches are refused during LOAD.
- Reset asserted mid-load aborts immediately: state EMPTY, `prog_len` 0, partial bytes retained but unreachable.
- `ld_start` and `fetch_req` in the same cycle: `ld_start` wins, and the fetch is not accepted.

## Structure
- Package `imem_pkg` holds:
  - the state enum (EMPTY, LOAD, READY);
  - `NOP_INSTR` = 32'h0000_0000;
  - the byte-order helper function.
- Sub-module `imem_byte_ram`: DEPTH_BYTES×8 array with one byte write port and one 4-byte registered read port. The FSM, checks and output registers stay in `imem_fetch_unit`.

## Test plan
- Load 8C 01 00 00 8C 02 00 01 (`ld_last` on the 8th byte), then fetch PC 0 and PC 4. Required: `instr` = 32'h8C010000, then 32'h8C020001, each valid one cycle after request; `prog_len` = 8.
- Same image with `BIG_ENDIAN`=0, fetch PC 0. Required: `instr` = 32'h0000018C.
- Fetch PC 2 → `fetch_fault`=1, `instr`=0. Fetch PC 12 with `prog_len`=8 → no fault, `instr`=0. With `DEPTH_BYTES`=256, fetch PC 256 → fault.
- With `DEPTH_BYTES`=8, load 9 bytes. Required: `ld_err`=1, state READY, `prog_len`=8, and the 9th byte is not written.
- Hold `stall`=1 for 3 cycles after a valid fetch of PC 0 while changing `fetch_pc`. Required: `instr` and `fetch_valid` stay unchanged; the first request after `stall` drops is served.
- Assert reset after 3 bytes of a load. Required: all outputs at reset values; fetch before reload returns nothing valid; `ld_start` reloads cleanly.
